// File: rtl/truth_sweep_pkg.sv
// Shared types and sizes for the truth-table sweeper.
// FSM encoding and vector/counter widths.
package truth_sweep_pkg;

  localparam int NUM_VECTORS = 8;
  localparam int IDX_W = 3;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/sweep_settle_timer.sv
// Settle down-counter for the sweeper.
// Loads on SETTLE entry, counts to zero, never wraps.
module sweep_settle_timer
  import truth_sweep_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             count_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // next count: reload, decrement, or hold at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (count_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps a 3-input gate through all 8 input vectors,
// captures its truth table and compares to expected.
module truth_table_sweeper
  import truth_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] expected,
  output logic [2:0] dut_in,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] captured,
  output logic [7:0] mismatch,
  output logic       pass
);

  localparam logic [CNT_W-1:0] LOAD_VAL =
    CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NUM_VECTORS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       exp_q, exp_d;
  logic [7:0]       cap_q, cap_d;
  logic [7:0]       mis_q, mis_d;
  logic             pass_q, pass_d;
  logic             tmr_load;
  logic             tmr_expire;
  logic [IDX_W-1:0] bit_sel;

  assign bit_sel = LAST_IDX - idx_q;

  sweep_settle_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (LOAD_VAL),
    .count_i    (state_q == S_SETTLE),
    .expire_o   (tmr_expire)
  );

  // sweep sequencing, capture and final compare
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    exp_d    = exp_q;
    cap_d    = cap_q;
    mis_d    = mis_q;
    pass_d   = pass_q;
    tmr_load = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          exp_d    = expected;
          cap_d    = '0;
          mis_d    = '0;
          pass_d   = 1'b0;
          idx_d    = '0;
          tmr_load = 1'b1;
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          pass_d  = 1'b0;
          state_d = S_IDLE;
        end else if (tmr_expire) begin
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (abort) begin
          pass_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cap_d[bit_sel] = dut_out;
          if (idx_q == LAST_IDX) begin
            mis_d   = cap_d ^ exp_q;
            pass_d  = (cap_d == exp_q);
            state_d = S_DONE;
          end else begin
            idx_d    = idx_q + IDX_W'(1);
            tmr_load = 1'b1;
            state_d  = S_SETTLE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      exp_q   <= '0;
      cap_q   <= '0;
      mis_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      exp_q   <= exp_d;
      cap_q   <= cap_d;
      mis_q   <= mis_d;
      pass_q  <= pass_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign dut_in   = ((state_q == S_SETTLE) ||
                     (state_q == S_SAMPLE)) ? idx_q : '0;
  assign captured = cap_q;
  assign mismatch = mis_q;
  assign pass     = pass_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: external gate model,
// directed and random sweeps checked by a cycle-level model.
module tb_truth_table_sweeper;

  localparam int S0 = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start0, abort0;
  logic [7:0] expected0;
  logic [2:0] dut_in0;
  logic       dut_out0;
  logic       busy0, done0, pass0;
  logic [7:0] captured0, mismatch0;
  logic [7:0] gate0_tt;

  logic       start1, abort1;
  logic [7:0] expected1;
  logic [2:0] dut_in1;
  logic       dut_out1;
  logic       busy1, done1, pass1;
  logic [7:0] captured1, mismatch1;
  logic [7:0] gate1_tt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // gates under test: truth table in hex-name order
  assign dut_out0 = gate0_tt[3'd7 - dut_in0];
  assign dut_out1 = gate1_tt[3'd7 - dut_in1];

  truth_table_sweeper #(.SETTLE_CYCLES(S0)) u0 (
    .clk(clk), .reset(reset), .start(start0),
    .abort(abort0), .expected(expected0),
    .dut_in(dut_in0), .dut_out(dut_out0),
    .busy(busy0), .done(done0), .captured(captured0),
    .mismatch(mismatch0), .pass(pass0)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(1)) u1 (
    .clk(clk), .reset(reset), .start(start1),
    .abort(abort1), .expected(expected1),
    .dut_in(dut_in1), .dut_out(dut_out1),
    .busy(busy1), .done(done1), .captured(captured1),
    .mismatch(mismatch1), .pass(pass1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // bits of tt sampled before an abort in cycle abort_at
  function automatic logic [7:0] partial(
    input logic [7:0] tt, input int abort_at);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++)
      if ((i + 1) * (S0 + 1) < abort_at) m[7 - i] = 1'b1;
    return tt & m;
  endfunction

  task automatic sweep(input logic [7:0] tt,
                       input logic [7:0] ex,
                       input int abort_at,
                       input string tag);
    int c;
    int done_cyc;
    bit aborts;
    aborts = (abort_at > 0) && (abort_at <= 8 * (S0 + 1));
    gate0_tt = tt;
    expected0 = ex;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    expected0 = 8'($urandom);
    c = 1;
    done_cyc = -1;
    check({tag, "_busy_c1"}, 32'(busy0), 32'd1);
    while (c < 80) begin
      if (done0 && done_cyc < 0) done_cyc = c;
      if (!busy0) break;
      abort0 = (c == abort_at);
      start0 = (abort_at == 0) && (c == 15);
      tick();
      c++;
    end
    abort0 = 1'b0;
    start0 = 1'b0;
    if (aborts) begin
      check({tag, "_idle_cyc"}, 32'(c), 32'(abort_at + 1));
      check({tag, "_nodone"}, 32'(done_cyc), 32'hffffffff);
      check({tag, "_cap"}, 32'(captured0),
            32'(partial(tt, abort_at)));
      check({tag, "_pass"}, 32'(pass0), 32'd0);
    end else begin
      check({tag, "_done_cyc"}, 32'(done_cyc),
            32'(1 + 8 * (S0 + 1)));
      check({tag, "_idle_cyc"}, 32'(c),
            32'(2 + 8 * (S0 + 1)));
      check({tag, "_cap"}, 32'(captured0), 32'(tt));
      check({tag, "_mis"}, 32'(mismatch0), 32'(tt ^ ex));
      check({tag, "_pass"}, 32'(pass0), 32'(tt == ex));
    end
    tick();
  endtask

  initial begin
    int dcnt;
    int dc[2];
    logic [7:0] rt, re;
    int ab;
    reset = 1'b1;
    start0 = 0; abort0 = 0; expected0 = '0;
    start1 = 0; abort1 = 0; expected1 = '0;
    gate0_tt = 8'h83;
    gate1_tt = 8'h83;
    tick(); tick();
    reset = 1'b0;
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_cap", 32'(captured0), 32'd0);
    check("rst_mis", 32'(mismatch0), 32'd0);
    check("rst_pass", 32'(pass0), 32'd0);
    check("rst_dutin", 32'(dut_in0), 32'd0);

    sweep(8'h83, 8'h83, 0, "g83_ok");
    sweep(8'h83, 8'h81, 0, "g83_bad");
    sweep(8'h83, 8'h83, 12, "abort12");
    check("abort12_cap80", 32'(captured0), 32'h80);
    sweep(8'h5a, 8'h5a, 41, "abort_in_done");
    sweep(8'hc3, 8'hc3, 40, "abort40");

    // reset in the middle of a sweep
    gate0_tt = 8'h83;
    expected0 = 8'h83;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int i = 1; i < 20; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", 32'(busy0), 32'd0);
    check("midrst_done", 32'(done0), 32'd0);
    check("midrst_cap", 32'(captured0), 32'd0);
    check("midrst_mis", 32'(mismatch0), 32'd0);
    check("midrst_pass", 32'(pass0), 32'd0);
    check("midrst_dutin", 32'(dut_in0), 32'd0);
    sweep(8'h83, 8'h83, 0, "after_rst");

    // start and abort together in IDLE
    start0 = 1'b1;
    abort0 = 1'b1;
    tick();
    check("sa_busy1", 32'(busy0), 32'd0);
    tick();
    check("sa_busy2", 32'(busy0), 32'd0);
    start0 = 1'b0;
    abort0 = 1'b0;
    tick();

    // random gates, expectations and aborts
    for (int k = 0; k < 8; k++) begin
      rt = 8'($urandom);
      re = ($urandom_range(0, 1) == 1) ? rt : 8'($urandom);
      ab = ($urandom_range(0, 2) == 0) ?
           int'($urandom_range(1, 45)) : 0;
      sweep(rt, re, ab, $sformatf("rnd%0d", k));
    end

    // SETTLE_CYCLES=1, start held high
    gate1_tt = 8'h96;
    expected1 = 8'h96;
    start1 = 1'b1;
    dcnt = 0;
    dc[0] = -1;
    dc[1] = -1;
    tick();
    for (int c = 1; c <= 40; c++) begin
      if (done1) begin
        if (dcnt < 2) dc[dcnt] = c;
        dcnt++;
        if (dcnt == 1)
          check("s1_cap", 32'(captured1), 32'h96);
      end
      if (c <= 16)
        check($sformatf("s1_dutin_c%0d", c),
              32'(dut_in1), 32'((c - 1) / 2));
      if (c >= 35) start1 = 1'b0;
      tick();
    end
    check("s1_done_a", 32'(dc[0]), 32'd17);
    check("s1_done_b", 32'(dc[1]), 32'd35);
    check("s1_done_n", 32'(dcnt), 32'd2);
    check("s1_idle", 32'(busy1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
